// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: FSM state encoding,
// default register-number width and the remaining-bubble counter width helper.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hazard_state_e;

  // Width able to hold max(a,b)-1, never narrower than one bit.
  function automatic int rem_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags a decode-stage source that reads the register a
// load in ID/EX is about to write. Register 0 is compared like any other.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src1_num_i,
  input  logic                  src1_vld_i,
  input  logic [REG_ADDR_W-1:0] src2_num_i,
  input  logic                  src2_vld_i,
  input  logic [REG_ADDR_W-1:0] dst_num_i,
  input  logic                  dst_vld_i,
  input  logic                  mem_read_i,
  output logic                  hazard_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = src1_vld_i && (src1_num_i == dst_num_i);
  assign src2_hit = src2_vld_i && (src2_num_i == dst_num_i);
  assign hazard_o = mem_read_i && dst_vld_i && (src1_hit || src2_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use stalls, taken-branch flushes and the
// forwarding-unit enable. Define HAZARD_PERF_EN to build the bubble counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1_num,
  input  logic                  id_src1_vld,
  input  logic [REG_ADDR_W-1:0] id_src2_num,
  input  logic                  id_src2_vld,
  input  logic [REG_ADDR_W-1:0] ex_dst_num,
  input  logic                  ex_dst_vld,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  fwd_en,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int REM_W = rem_width(LOAD_STALL_CYCLES, FLUSH_CYCLES);
  localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_CYCLES - 1);

  hazard_state_e    state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             fwd_en_q;
  logic             hazard;

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
    .src1_num_i (id_src1_num),
    .src1_vld_i (id_src1_vld),
    .src2_num_i (id_src2_num),
    .src2_vld_i (id_src2_vld),
    .dst_num_i  (ex_dst_num),
    .dst_vld_i  (ex_dst_vld),
    .mem_read_i (ex_mem_read),
    .hazard_o   (hazard)
  );

  // Mealy decode: the pipeline reacts in the same cycle the condition appears.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    state_d        = state_q;
    rem_d          = rem_q;
    if (rst) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      rem_d        = FLUSH_RELOAD;
      state_d      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            rem_d          = STALL_RELOAD;
            state_d        = (LOAD_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
          end
        end
        ST_STALL: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          rem_d          = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          rem_d        = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      rem_q    <= '0;
      fwd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      fwd_en_q <= ~id_ex_bubble;
    end
  end

  assign fwd_en = fwd_en_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && !if_id_flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance (A) and one with
// three-cycle load stalls and 2-bit counters (B) share the same stimulus.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s1_num, s2_num, dst_num;
  logic       s1_vld, s2_vld, dst_vld, mem_rd, br;

  logic        a_pc, a_ifid, a_flush, a_bub, a_fwd;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pc, b_ifid, b_flush, b_bub, b_fwd;
  logic [1:0]  b_scnt, b_fcnt;
  logic [3:0]  a_ctl, b_ctl;

  int checks = 0;
  int errors = 0;

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble}
  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_FLUSH = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b0001;

  assign a_ctl = {a_pc, a_ifid, a_flush, a_bub};
  assign b_ctl = {b_pc, b_ifid, b_flush, b_bub};

  always #5 clk = ~clk;

  hazard_stall_unit u_a (
    .clk(clk), .rst(rst),
    .id_src1_num(s1_num), .id_src1_vld(s1_vld),
    .id_src2_num(s2_num), .id_src2_vld(s2_vld),
    .ex_dst_num(dst_num), .ex_dst_vld(dst_vld), .ex_mem_read(mem_rd),
    .branch_taken(br),
    .pc_write_en(a_pc), .if_id_write_en(a_ifid), .if_id_flush(a_flush),
    .id_ex_bubble(a_bub), .fwd_en(a_fwd),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .id_src1_num(s1_num), .id_src1_vld(s1_vld),
    .id_src2_num(s2_num), .id_src2_vld(s2_vld),
    .ex_dst_num(dst_num), .ex_dst_vld(dst_vld), .ex_mem_read(mem_rd),
    .branch_taken(br),
    .pc_write_en(b_pc), .if_id_write_en(b_ifid), .if_id_flush(b_flush),
    .id_ex_bubble(b_bub), .fwd_en(b_fwd),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_num = 4'd0; s1_vld = 1'b0; s2_num = 4'd0; s2_vld = 1'b0;
    dst_num = 4'd0; dst_vld = 1'b0; mem_rd = 1'b0; br = 1'b0;
  endtask

  task automatic set_hazard();
    mem_rd = 1'b1; dst_vld = 1'b1; dst_num = 4'd3; s1_num = 4'd3; s1_vld = 1'b1;
  endtask

  task automatic reset_pulse();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (a_ctl !== CTL_RST) begin errors++; $display("FAIL rst_ctl got %b exp %b", a_ctl, CTL_RST); end
    checks++;
    if ({a_fwd, b_fwd} !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b exp 00", {a_fwd, b_fwd}); end
    checks++;
    if ({a_scnt, a_fcnt} !== 32'd0) begin errors++; $display("FAIL rst_cnt got %h exp 0", {a_scnt, a_fcnt}); end
    rst = 1'b0;
    #1;
    checks++;
    if (a_ctl !== CTL_RUN) begin errors++; $display("FAIL rst_release_ctl got %b exp %b", a_ctl, CTL_RUN); end
    cyc();
    checks++;
    if (a_fwd !== 1'b1) begin errors++; $display("FAIL rst_release_fwd got %b exp 1", a_fwd); end
  endtask

  task automatic test_load_use();
    reset_pulse();
    set_hazard();
    #1;
    checks++;
    if (a_ctl !== CTL_STALL) begin errors++; $display("FAIL lu_a_ctl got %b exp %b", a_ctl, CTL_STALL); end
    checks++;
    if (b_ctl !== CTL_STALL) begin errors++; $display("FAIL lu_b_ctl0 got %b exp %b", b_ctl, CTL_STALL); end
    cyc();
    idle();
    #1;
    checks++;
    if (a_fwd !== 1'b0) begin errors++; $display("FAIL lu_a_fwd got %b exp 0", a_fwd); end
    checks++;
    if (a_ctl !== CTL_RUN) begin errors++; $display("FAIL lu_a_resume got %b exp %b", a_ctl, CTL_RUN); end
    checks++;
    if (b_ctl !== CTL_STALL) begin errors++; $display("FAIL lu_b_ctl1 got %b exp %b", b_ctl, CTL_STALL); end
    cyc();
    checks++;
    if (b_ctl !== CTL_STALL) begin errors++; $display("FAIL lu_b_ctl2 got %b exp %b", b_ctl, CTL_STALL); end
    checks++;
    if (a_fwd !== 1'b1) begin errors++; $display("FAIL lu_a_fwd2 got %b exp 1", a_fwd); end
    cyc();
    checks++;
    if (b_ctl !== CTL_RUN) begin errors++; $display("FAIL lu_b_resume got %b exp %b", b_ctl, CTL_RUN); end
  endtask

  typedef struct {
    logic       mr, dv;
    logic [3:0] d, s1;
    logic       s1v;
    logic [3:0] s2;
    logic       s2v, haz;
  } vec_t;

  task automatic test_patterns();
    vec_t tbl[5];
    tbl[0] = '{1'b1, 1'b1, 4'd5, 4'd3, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'd5, 4'd3, 1'b1, 4'd5, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0};
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      mem_rd = tbl[i].mr; dst_vld = tbl[i].dv; dst_num = tbl[i].d;
      s1_num = tbl[i].s1; s1_vld = tbl[i].s1v; s2_num = tbl[i].s2; s2_vld = tbl[i].s2v;
      #1;
      checks++;
      if (a_ctl !== (tbl[i].haz ? CTL_STALL : CTL_RUN)) begin
        errors++; $display("FAIL pat%0d_ctl got %b exp_hazard %b", i, a_ctl, tbl[i].haz);
      end
      cyc();
      checks++;
      if (a_fwd !== !tbl[i].haz) begin
        errors++; $display("FAIL pat%0d_fwd got %b exp %b", i, a_fwd, !tbl[i].haz);
      end
      idle();
    end
  endtask

  task automatic test_branch_flush();
    reset_pulse();
    br = 1'b1;
    #1;
    checks++;
    if (a_ctl !== CTL_FLUSH) begin errors++; $display("FAIL br_ctl0 got %b exp %b", a_ctl, CTL_FLUSH); end
    cyc();
    br = 1'b0;
    #1;
    checks++;
    if (a_ctl !== CTL_FLUSH) begin errors++; $display("FAIL br_ctl1 got %b exp %b", a_ctl, CTL_FLUSH); end
    checks++;
    if (a_fwd !== 1'b0) begin errors++; $display("FAIL br_fwd1 got %b exp 0", a_fwd); end
    cyc();
    checks++;
    if (a_ctl !== CTL_RUN) begin errors++; $display("FAIL br_ctl2 got %b exp %b", a_ctl, CTL_RUN); end
    checks++;
    if (a_fwd !== 1'b0) begin errors++; $display("FAIL br_fwd2 got %b exp 0", a_fwd); end
    cyc();
    checks++;
    if (a_fwd !== 1'b1) begin errors++; $display("FAIL br_fwd3 got %b exp 1", a_fwd); end
  endtask

  task automatic test_branch_aborts_stall();
    reset_pulse();
    set_hazard();
    #1;
    checks++;
    if (b_ctl !== CTL_STALL) begin errors++; $display("FAIL abort_ctl0 got %b exp %b", b_ctl, CTL_STALL); end
    cyc();
    br = 1'b1;
    #1;
    checks++;
    if (b_ctl !== CTL_FLUSH) begin errors++; $display("FAIL abort_ctl1 got %b exp %b", b_ctl, CTL_FLUSH); end
    cyc();
    br = 1'b0;
    #1;
    checks++;
    if (b_ctl !== CTL_FLUSH) begin errors++; $display("FAIL abort_ctl2 got %b exp %b", b_ctl, CTL_FLUSH); end
    cyc();
    idle();
    #1;
    checks++;
    if (b_ctl !== CTL_RUN) begin errors++; $display("FAIL abort_ctl3 got %b exp %b", b_ctl, CTL_RUN); end
  endtask

  task automatic test_reset_mid_flush();
    reset_pulse();
    br = 1'b1;
    cyc();
    br = 1'b0;
    #1;
    checks++;
    if (a_ctl !== CTL_FLUSH) begin errors++; $display("FAIL rmf_in_flush got %b exp %b", a_ctl, CTL_FLUSH); end
    rst = 1'b1;
    #1;
    checks++;
    if (a_ctl !== CTL_RST) begin errors++; $display("FAIL rmf_rst_ctl got %b exp %b", a_ctl, CTL_RST); end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (a_ctl !== CTL_RUN) begin errors++; $display("FAIL rmf_run got %b exp %b", a_ctl, CTL_RUN); end
    checks++;
    if (a_fwd !== 1'b0) begin errors++; $display("FAIL rmf_fwd got %b exp 0", a_fwd); end
    checks++;
    if ({a_scnt, a_fcnt, b_scnt, b_fcnt} !== 36'd0) begin
      errors++; $display("FAIL rmf_cnt got %h exp 0", {a_scnt, a_fcnt, b_scnt, b_fcnt});
    end
  endtask

  task automatic test_perf_saturate();
    logic [1:0]  exp_b;
    logic [15:0] exp_as, exp_af;
    reset_pulse();
    set_hazard();
    for (int k = 1; k <= 5; k++) begin
      cyc();
`ifdef HAZARD_PERF_EN
      exp_b  = (k > 3) ? 2'd3 : 2'(k);
      exp_as = 16'(k);
`else
      exp_b  = 2'd0;
      exp_as = 16'd0;
`endif
      checks++;
      if (b_scnt !== exp_b) begin errors++; $display("FAIL perf_b_scnt%0d got %0d exp %0d", k, b_scnt, exp_b); end
      checks++;
      if (a_scnt !== exp_as) begin errors++; $display("FAIL perf_a_scnt%0d got %0d exp %0d", k, a_scnt, exp_as); end
    end
    idle();
    br = 1'b1;
    cyc();
    br = 1'b0;
    cyc();
`ifdef HAZARD_PERF_EN
    exp_af = 16'd2;
    exp_as = 16'd5;
`else
    exp_af = 16'd0;
    exp_as = 16'd0;
`endif
    checks++;
    if (a_fcnt !== exp_af) begin errors++; $display("FAIL perf_a_fcnt got %0d exp %0d", a_fcnt, exp_af); end
    checks++;
    if (a_scnt !== exp_as) begin errors++; $display("FAIL perf_a_scnt_hold got %0d exp %0d", a_scnt, exp_as); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_patterns();
    test_branch_flush();
    test_branch_aborts_stall();
    test_reset_mid_flush();
    test_perf_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
